// File: rtl/cpu_pkg.sv
// Shared widths and the pipeline-stage bundle used by the operand forwarding logic.
// Build option: OPERAND_FWD_WB_BYPASS_EN enables forwarding from the WB register.
package cpu_pkg;

    localparam int unsigned RegSelW = 3;
    localparam int unsigned DataW   = 16;

    typedef logic [RegSelW-1:0] regsel_t;
    typedef logic [DataW-1:0]   data_t;

    // One in-flight register write as seen at a pipeline stage.
    typedef struct packed {
        logic    wr;
        regsel_t rd;
        data_t   data;
        logic    is_load;
    } stage_t;

    // A stage feeds a source only if the source is consumed and the stage writes that register.
    function automatic logic src_hit(stage_t s, regsel_t rs, logic used);
        return used && s.wr && (s.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand source selection: youngest producer wins (EX > MEM > WB > register file).
// Build option: OPERAND_FWD_WB_BYPASS_EN forwards from WB; otherwise a WB match stalls.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic   [RegSelW-1:0] rs,
    input  logic                 used,
    input  logic   [DataW-1:0]   rf_data,
    input  stage_t               ex,
    input  stage_t               mem,
    input  stage_t               wb,
    output logic   [DataW-1:0]   op,
    output logic                 stall
);

`ifdef OPERAND_FWD_WB_BYPASS_EN
    logic unused_bits;
    assign unused_bits = mem.is_load ^ wb.is_load;
`else
    logic unused_bits;
    assign unused_bits = mem.is_load ^ wb.is_load ^ (^wb.data);
`endif

    // Priority select; a load still in EX has no data yet, so it can only stall.
    always_comb begin
        op    = rf_data;
        stall = 1'b0;
        if (src_hit(ex, rs, used)) begin
            if (ex.is_load) begin
                stall = 1'b1;
            end else begin
                op = ex.data;
            end
        end else if (src_hit(mem, rs, used)) begin
            op = mem.data;
        end
`ifdef OPERAND_FWD_WB_BYPASS_EN
        else if (src_hit(wb, rs, used)) begin
            op = wb.data;
        end
`else
        // Register file returns the old value while WB is writing, so wait it out.
        if (src_hit(wb, rs, used)) begin
            stall = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/operand_fwd.sv
// Operand forwarding and load-use hazard detection for a 3-stage-after-decode pipeline.
// Holds the MEM and WB stage registers and drives the register file write port from WB.
// Build option: OPERAND_FWD_WB_BYPASS_EN (see fwd_mux).
module operand_fwd
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [RegSelW-1:0] id_rs1,
    input  logic [RegSelW-1:0] id_rs2,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic [DataW-1:0]   rf_read1data,
    input  logic [DataW-1:0]   rf_read2data,
    input  logic               ex_valid,
    input  logic               ex_wr,
    input  logic               ex_is_load,
    input  logic [RegSelW-1:0] ex_rd,
    input  logic [DataW-1:0]   ex_data,
    input  logic [DataW-1:0]   mem_load_data,
    output logic [DataW-1:0]   op1,
    output logic [DataW-1:0]   op2,
    output logic               stall,
    output logic               wb_write,
    output logic [RegSelW-1:0] wb_regsel,
    output logic [DataW-1:0]   wb_data
);

    stage_t ex_s;
    stage_t mem_q;
    stage_t mem_fwd;
    stage_t wb_q;
    logic   stall1;
    logic   stall2;

    // EX bundle and the resolved MEM result (load data replaces the ALU value).
    always_comb begin
        ex_s         = '0;
        ex_s.wr      = ex_valid & ex_wr;
        ex_s.rd      = ex_rd;
        ex_s.data    = ex_data;
        ex_s.is_load = ex_is_load;

        mem_fwd         = '0;
        mem_fwd.wr      = mem_q.wr;
        mem_fwd.rd      = mem_q.rd;
        mem_fwd.data    = mem_q.is_load ? mem_load_data : mem_q.data;
        mem_fwd.is_load = 1'b0;
    end

    // MEM and WB stage registers; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= ex_s;
            wb_q  <= mem_fwd;
        end
    end

    assign wb_write  = wb_q.wr;
    assign wb_regsel = wb_q.rd;
    assign wb_data   = wb_q.data;

    fwd_mux u_fwd_mux1 (
        .rs      (id_rs1),
        .used    (id_rs1_used),
        .rf_data (rf_read1data),
        .ex      (ex_s),
        .mem     (mem_fwd),
        .wb      (wb_q),
        .op      (op1),
        .stall   (stall1)
    );

    fwd_mux u_fwd_mux2 (
        .rs      (id_rs2),
        .used    (id_rs2_used),
        .rf_data (rf_read2data),
        .ex      (ex_s),
        .mem     (mem_fwd),
        .wb      (wb_q),
        .op      (op2),
        .stall   (stall2)
    );

    assign stall = stall1 | stall2;

endmodule

// File: doc/operand_fwd.md
OPERAND_FWD -- requirements
Module: operand_fwd

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports id_rs1, id_rs2  in  3 each  decode-stage source register selectors (same values driven to the register file read selects).
REQ-004 SHALL have ports id_rs1_used, id_rs2_used  in  1 each  source operand actually consumed by the decoding instruction.
REQ-005 SHALL have ports rf_read1data, rf_read2data  in  16 each  register file read data for id_rs1/id_rs2.
REQ-006 SHALL have ports ex_valid, ex_wr, ex_is_load  in  1 each  EX-stage instruction valid, writes a register, is a load.
REQ-007 SHALL have ports ex_rd  in  3 and ex_data  in  16  EX destination and ALU result.
REQ-008 SHALL have port mem_load_data  in  16  data memory read result for the instruction in MEM.
REQ-009 SHALL have ports op1, op2  out  16 each  forwarded operands to the ID/EX register.
REQ-010 SHALL have port stall  out  1  decode must hold; upstream inserts an EX bubble.
REQ-011 SHALL have ports wb_write  out  1, wb_regsel  out  3, wb_data  out  16  register file write port drive.

Function
REQ-012 SHALL capture {ex_valid&ex_wr, ex_rd, ex_data, ex_is_load} into the MEM register each rising edge.
REQ-013 SHALL compute mem_result = mem_load_data if mem_is_load, else captured ex_data.
REQ-014 SHALL capture {mem_wr, mem_rd, mem_result} into the WB register each rising edge; wb_write/wb_regsel/wb_data SHALL be driven directly from it (register file writes two edges after EX).
REQ-015 SHALL select each operand with priority EX > MEM > WB > rf_readNdata, matching only sources with used=1 and stages with write enable=1 and rd == rs.
REQ-016 SHALL, for EX match with ex_is_load=1, assert stall instead of forwarding (load-use, one bubble).
REQ-017 SHALL forward from MEM after the MEM load result is valid (mem_result), so the post-stall cycle needs no second stall.
REQ-018 SHALL treat all 8 registers as writable; no hard-wired zero register.
REQ-019 SHALL, when EX and MEM both match, use EX; stale MEM/WB values never override younger data.
REQ-020 SHALL keep stall purely combinational from current inputs and MEM/WB state; no stall state held internally.
REQ-021 SHALL leave op1/op2 undefined-don't-care only when used=0; otherwise exactly one source per priority rule.

Reset
REQ-022 SHALL clear mem_wr, wb_write to 0 and mem_rd, wb_regsel, mem/wb data to 0 on rst, immediately and independent of clk.
REQ-023 SHALL, with rst asserted mid-operation, discard in-flight MEM/WB writes (no register file write after reset).

Configuration
REQ-024 SHALL support macro OPERAND_FWD_WB_BYPASS_EN: defined -> WB stage forwards per REQ-015 (needed because the register file reads and writes on the same falling edge and returns the old value).
REQ-025 SHALL, without OPERAND_FWD_WB_BYPASS_EN, drop WB forwarding and assert stall on any used-source match against the WB register.

Structure
REQ-026 SHALL place register-selector width (3), data width (16) and the stage bundle typedef {wr, rd, data, is_load} in shared package cpu_pkg.
REQ-027 SHALL implement per-operand selection in one sub-module fwd_mux, instantiated twice.

Verification
REQ-028 SHALL cover EX-to-ID: ex_wr=1, ex_rd=3, ex_data=16'h1234, id_rs1=3 used -> op1=16'h1234, stall=0.
REQ-029 SHALL cover load-use: ex_is_load=1, ex_rd=2, id_rs2=2 used -> stall=1; next cycle ex_valid=0, mem_load_data=16'hBEEF -> op2=16'hBEEF, stall=0.
REQ-030 SHALL cover priority: EX rd=5 data 16'h0001, MEM rd=5 data 16'h0002 -> op1=16'h0001.
REQ-031 SHALL cover WB bypass: WB rd=4 data 16'hA5A5, rf_read1data=16'h0000, id_rs1=4 -> op1=16'hA5A5 with macro; stall=1 without.
REQ-032 SHALL cover unused source: id_rs1=3 used=0 with EX load rd=3 -> stall=0.
REQ-033 SHALL cover reset: rst pulse with MEM/WB holding writes -> wb_write=0 asynchronously, no write two edges later.
